// File: rtl/fil2dma_rd_ctrl_if.sv
// FIFO read port and DMA write-data stream seen by the fil2dma read controller.
// master = controller side, slave = FIFO/DMA side.
interface fil2dma_rd_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rd;
  logic              dma_valid;
  logic [DATA_W-1:0] dma_data;
  logic              dma_last;
  logic              dma_ready;

  modport master (
    input  fifo_empty, fifo_rdata, dma_ready,
    output fifo_rd, dma_valid, dma_data, dma_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, dma_ready,
    input  fifo_rd, dma_valid, dma_data, dma_last
  );
endinterface

// File: rtl/fil2dma_rd_ctrl.sv
// Pops the fil2dma FIFO, hides its 1-cycle read latency in a 2-entry skid buffer
// and streams words to the DMA engine, flagging every BURST_LEN-th beat as last.
//
//  state | meaning
//  IDLE  | nothing buffered or in flight, no reads
//  RUN   | reading FIFO whenever a buffer slot is free
//  DRAIN | reads stopped, finishing in-flight word and emptying buffer
module fil2dma_rd_ctrl #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              fil_clk,
  input  logic              fil_rst,
  input  logic              rd_en,
  fil2dma_rd_ctrl_if.master bus,
  output logic              busy,
  output logic [CNT_W-1:0]  burst_cnt
);
  localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              inflight;
  logic [BI_W-1:0]   beat_idx;
  logic              pop;
  logic              rd;
  logic [2:0]        used;

  assign pop  = bus.dma_valid & bus.dma_ready;
  assign used = {1'b0, occ} + {2'b00, inflight};
  // A slot freed by this cycle's transfer is reusable at once, which keeps
  // the stream at one beat per cycle while never exceeding two entries.
  assign rd   = (state == RUN) && !bus.fifo_empty && (used < (3'd2 + {2'b00, pop}));

  assign bus.fifo_rd   = rd;
  assign bus.dma_valid = (occ != 2'd0);
  assign bus.dma_data  = skid[rd_ptr];
  assign bus.dma_last  = (beat_idx == LAST_IDX) && bus.dma_valid;

  always_ff @(posedge fil_clk or posedge fil_rst) begin
    if (fil_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      skid[0]   <= '0;
      skid[1]   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      beat_idx  <= '0;
      burst_cnt <= '0;
    end else begin
      inflight <= rd;
      if (inflight) begin
        skid[wr_ptr] <= bus.fifo_rdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (beat_idx == LAST_IDX) begin
          beat_idx  <= '0;
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (rd_en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!rd_en) state <= DRAIN;
        end
        DRAIN: begin
          if (rd_en) begin
            state <= RUN;
          end else if (occ == 2'd0 && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
